// File: rtl/next_pulse_pkg.sv
// Shared types and helpers for the NEXT strobe generator:
// FSM state encoding and the shared-counter width calculation.
package next_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // One bit of headroom above the largest terminal count.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/next_pulse_gen_sync2.sv
// Single-bit two-flop synchroniser for the asynchronous button pin.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/next_pulse_gen.sv
// Debounced push-button to single-cycle NEXT strobe.
// Optional auto-repeat while held: define NEXT_AUTOREPEAT_EN.
module next_pulse_gen
  import next_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic NEXT,
  output logic btn_level
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s;
  state_t        state;
  logic [CW-1:0] cnt;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (btn_s)
  );

`ifdef NEXT_AUTOREPEAT_EN
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
  logic          rep_phase;
  logic [CW-1:0] rep_last;
  assign rep_last = rep_phase ? PER_LAST : DLY_LAST;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      NEXT      <= 1'b0;
      btn_level <= 1'b0;
`ifdef NEXT_AUTOREPEAT_EN
      rep_phase <= 1'b0;
`endif
    end else begin
      NEXT <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            NEXT      <= 1'b1;
            btn_level <= 1'b1;
`ifdef NEXT_AUTOREPEAT_EN
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end else begin
`ifdef NEXT_AUTOREPEAT_EN
            // The !NEXT guard keeps the strobe single-cycle even for 1-cycle limits.
            if (cnt >= rep_last) begin
              if (!NEXT) begin
                NEXT      <= 1'b1;
                cnt       <= '0;
                rep_phase <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
`else
            cnt <= '0;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
